// File: rtl/ysyx_24100006_axi_sram_pkg.sv
//==============================================================================
// ysyx_24100006_axi_sram_pkg : response codes, FSM encodings, beat decode helpers
// Rev 1.0
//==============================================================================
`default_nettype none

package ysyx_24100006_axi_sram_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int LAT_W = 4;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_WAIT = 2'd2,
    W_RESP = 2'd3
  } wr_state_e;

  // Decode errors outrank size errors since DECERR is the numerically worse code.
  function automatic logic [1:0] beat_resp(input logic [31:0] addr,
                                           input logic [2:0]  size,
                                           input logic [31:0] base,
                                           input logic [31:0] depth);
    logic [31:0] off;
    off = addr - base;
    if ((addr < base) || ((off >> 2) >= depth))
      beat_resp = RESP_DECERR;
    else if (size > 3'd2)
      beat_resp = RESP_SLVERR;
    else
      beat_resp = RESP_OKAY;
  endfunction

  function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
    worst_resp = (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_24100006_axi_sram_if.sv
//==============================================================================
// ysyx_24100006_axi_sram_if : AXI4 AR/R/AW/W/B channel bundle for the SRAM slave
// Rev 1.0
//==============================================================================
`default_nettype none

interface ysyx_24100006_axi_sram_if;

  logic        sram_axi_arvalid;
  logic        sram_axi_arready;
  logic [31:0] sram_axi_araddr;
  logic [7:0]  sram_axi_arlen;
  logic [2:0]  sram_axi_arsize;

  logic        sram_axi_rvalid;
  logic        sram_axi_rready;
  logic [31:0] sram_axi_rdata;
  logic [1:0]  sram_axi_rresp;
  logic        sram_axi_rlast;

  logic        sram_axi_awvalid;
  logic        sram_axi_awready;
  logic [31:0] sram_axi_awaddr;
  logic [7:0]  sram_axi_awlen;
  logic [2:0]  sram_axi_awsize;

  logic        sram_axi_wvalid;
  logic        sram_axi_wready;
  logic [31:0] sram_axi_wdata;
  logic [3:0]  sram_axi_wstrb;
  logic        sram_axi_wlast;

  logic        sram_axi_bvalid;
  logic        sram_axi_bready;
  logic [1:0]  sram_axi_bresp;

  modport slave (
    input  sram_axi_arvalid, sram_axi_araddr, sram_axi_arlen, sram_axi_arsize,
    output sram_axi_arready,
    output sram_axi_rvalid, sram_axi_rdata, sram_axi_rresp, sram_axi_rlast,
    input  sram_axi_rready,
    input  sram_axi_awvalid, sram_axi_awaddr, sram_axi_awlen, sram_axi_awsize,
    output sram_axi_awready,
    input  sram_axi_wvalid, sram_axi_wdata, sram_axi_wstrb, sram_axi_wlast,
    output sram_axi_wready,
    output sram_axi_bvalid, sram_axi_bresp,
    input  sram_axi_bready
  );

  modport master (
    output sram_axi_arvalid, sram_axi_araddr, sram_axi_arlen, sram_axi_arsize,
    input  sram_axi_arready,
    input  sram_axi_rvalid, sram_axi_rdata, sram_axi_rresp, sram_axi_rlast,
    output sram_axi_rready,
    output sram_axi_awvalid, sram_axi_awaddr, sram_axi_awlen, sram_axi_awsize,
    input  sram_axi_awready,
    output sram_axi_wvalid, sram_axi_wdata, sram_axi_wstrb, sram_axi_wlast,
    input  sram_axi_wready,
    input  sram_axi_bvalid, sram_axi_bresp,
    output sram_axi_bready
  );

endinterface

`default_nettype wire

// File: rtl/ysyx_24100006_lat_cnt.sv
//==============================================================================
// ysyx_24100006_lat_cnt : loadable down-counter, done high on the final count cycle
// Rev 1.0
//==============================================================================
`default_nettype none

module ysyx_24100006_lat_cnt
  import ysyx_24100006_axi_sram_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LAT_W-1:0] load,
  output logic             done
);

  logic [LAT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (start)
      cnt <= load;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign done = (cnt == LAT_W'(1));

endmodule

`default_nettype wire

// File: rtl/ysyx_24100006_axi_sram.sv
//==============================================================================
// ysyx_24100006_axi_sram : AXI4 INCR-burst SRAM slave, independent read/write FSMs
// Rev 1.0
//==============================================================================
`default_nettype none

module ysyx_24100006_axi_sram
  import ysyx_24100006_axi_sram_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          RD_LAT      = 2,
  parameter int          WR_LAT      = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  ysyx_24100006_axi_sram_if.slave axi
);

  localparam int               IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0]      DEPTH_32  = 32'(DEPTH_WORDS);
  localparam logic [LAT_W-1:0] RD_LOAD   = LAT_W'(RD_LAT - 1);
  localparam logic [LAT_W-1:0] WR_LOAD   = LAT_W'(WR_LAT - 1);
  localparam bit               RD_DIRECT = (RD_LAT == 1);
  localparam bit               WR_DIRECT = (WR_LAT == 1);

  logic [31:0] mem [DEPTH_WORDS];

  rd_state_e        rd_state, rd_state_nxt;
  logic [31:0]      rd_addr, rd_addr_nxt;
  logic [7:0]       rd_len, rd_len_nxt, rd_beat, rd_beat_nxt;
  logic [2:0]       rd_size, rd_size_nxt;
  logic [31:0]      rd_data;
  logic [1:0]       rd_resp, rd_sample_resp;
  logic             rd_sample, rd_cnt_start, rd_cnt_done;
  logic [IDX_W-1:0] rd_idx;

  wr_state_e        wr_state, wr_state_nxt;
  logic [31:0]      wr_addr, wr_addr_nxt;
  logic [7:0]       wr_len, wr_len_nxt, wr_beat, wr_beat_nxt;
  logic [2:0]       wr_size, wr_size_nxt;
  logic [1:0]       wr_resp, wr_resp_nxt, wr_beat_resp;
  logic             wr_we, wr_cnt_start, wr_cnt_done;
  logic [IDX_W-1:0] wr_idx;

  ysyx_24100006_lat_cnt u_rd_lat (
    .clk   (clk),
    .reset (reset),
    .start (rd_cnt_start),
    .load  (RD_LOAD),
    .done  (rd_cnt_done)
  );

  ysyx_24100006_lat_cnt u_wr_lat (
    .clk   (clk),
    .reset (reset),
    .start (wr_cnt_start),
    .load  (WR_LOAD),
    .done  (wr_cnt_done)
  );

  // Storage is sampled with the next-cycle address so RD_LAT=1 can skip R_WAIT.
  assign rd_sample_resp = beat_resp(rd_addr_nxt, rd_size_nxt, ADDR_BASE, DEPTH_32);
  assign rd_idx         = IDX_W'((rd_addr_nxt - ADDR_BASE) >> 2);

  always_comb begin
    rd_state_nxt = rd_state;
    rd_addr_nxt  = rd_addr;
    rd_len_nxt   = rd_len;
    rd_size_nxt  = rd_size;
    rd_beat_nxt  = rd_beat;
    rd_sample    = 1'b0;
    rd_cnt_start = 1'b0;
    unique case (rd_state)
      R_IDLE: begin
        if (axi.sram_axi_arvalid) begin
          rd_addr_nxt = axi.sram_axi_araddr;
          rd_len_nxt  = axi.sram_axi_arlen;
          rd_size_nxt = axi.sram_axi_arsize;
          rd_beat_nxt = '0;
          if (RD_DIRECT) begin
            rd_state_nxt = R_DATA;
            rd_sample    = 1'b1;
          end else begin
            rd_state_nxt = R_WAIT;
            rd_cnt_start = 1'b1;
          end
        end
      end
      R_WAIT: begin
        if (rd_cnt_done) begin
          rd_state_nxt = R_DATA;
          rd_sample    = 1'b1;
        end
      end
      R_DATA: begin
        if (axi.sram_axi_rready) begin
          if (rd_beat == rd_len) begin
            rd_state_nxt = R_IDLE;
          end else begin
            rd_addr_nxt = rd_addr + 32'd4;
            rd_beat_nxt = rd_beat + 8'd1;
            if (RD_DIRECT) begin
              rd_state_nxt = R_DATA;
              rd_sample    = 1'b1;
            end else begin
              rd_state_nxt = R_WAIT;
              rd_cnt_start = 1'b1;
            end
          end
        end
      end
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_state <= R_IDLE;
      rd_addr  <= '0;
      rd_len   <= '0;
      rd_size  <= '0;
      rd_beat  <= '0;
      rd_data  <= '0;
      rd_resp  <= RESP_OKAY;
    end else begin
      rd_state <= rd_state_nxt;
      rd_addr  <= rd_addr_nxt;
      rd_len   <= rd_len_nxt;
      rd_size  <= rd_size_nxt;
      rd_beat  <= rd_beat_nxt;
      if (rd_sample) begin
        rd_resp <= rd_sample_resp;
        rd_data <= (rd_sample_resp == RESP_OKAY) ? mem[rd_idx] : '0;
      end
    end
  end

  assign axi.sram_axi_arready = (rd_state == R_IDLE);
  assign axi.sram_axi_rvalid  = (rd_state == R_DATA);
  assign axi.sram_axi_rdata   = rd_data;
  assign axi.sram_axi_rresp   = rd_resp;
  assign axi.sram_axi_rlast   = (rd_state == R_DATA) && (rd_beat == rd_len);

  assign wr_beat_resp = beat_resp(wr_addr, wr_size, ADDR_BASE, DEPTH_32);
  assign wr_idx       = IDX_W'((wr_addr - ADDR_BASE) >> 2);

  always_comb begin
    wr_state_nxt = wr_state;
    wr_addr_nxt  = wr_addr;
    wr_len_nxt   = wr_len;
    wr_size_nxt  = wr_size;
    wr_beat_nxt  = wr_beat;
    wr_resp_nxt  = wr_resp;
    wr_we        = 1'b0;
    wr_cnt_start = 1'b0;
    unique case (wr_state)
      W_IDLE: begin
        if (axi.sram_axi_awvalid) begin
          wr_addr_nxt  = axi.sram_axi_awaddr;
          wr_len_nxt   = axi.sram_axi_awlen;
          wr_size_nxt  = axi.sram_axi_awsize;
          wr_beat_nxt  = '0;
          wr_resp_nxt  = RESP_OKAY;
          wr_state_nxt = W_DATA;
        end
      end
      W_DATA: begin
        if (axi.sram_axi_wvalid) begin
          wr_we       = (wr_beat_resp == RESP_OKAY);
          wr_resp_nxt = worst_resp(wr_resp, wr_beat_resp);
          // A short wlast and an exhausted awlen both close the burst.
          if (axi.sram_axi_wlast || (wr_beat == wr_len)) begin
            if (WR_DIRECT) begin
              wr_state_nxt = W_RESP;
            end else begin
              wr_state_nxt = W_WAIT;
              wr_cnt_start = 1'b1;
            end
          end else begin
            wr_addr_nxt = wr_addr + 32'd4;
            wr_beat_nxt = wr_beat + 8'd1;
          end
        end
      end
      W_WAIT: begin
        if (wr_cnt_done)
          wr_state_nxt = W_RESP;
      end
      W_RESP: begin
        if (axi.sram_axi_bready)
          wr_state_nxt = W_IDLE;
      end
      default: wr_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_state <= W_IDLE;
      wr_addr  <= '0;
      wr_len   <= '0;
      wr_size  <= '0;
      wr_beat  <= '0;
      wr_resp  <= RESP_OKAY;
    end else begin
      wr_state <= wr_state_nxt;
      wr_addr  <= wr_addr_nxt;
      wr_len   <= wr_len_nxt;
      wr_size  <= wr_size_nxt;
      wr_beat  <= wr_beat_nxt;
      wr_resp  <= wr_resp_nxt;
    end
  end

  // Storage keeps its contents through reset.
  always_ff @(posedge clk) begin
    if (wr_we) begin
      for (int b = 0; b < 4; b++) begin
        if (axi.sram_axi_wstrb[b])
          mem[wr_idx][8*b +: 8] <= axi.sram_axi_wdata[8*b +: 8];
      end
    end
  end

  assign axi.sram_axi_awready = (wr_state == W_IDLE);
  assign axi.sram_axi_wready  = (wr_state == W_DATA);
  assign axi.sram_axi_bvalid  = (wr_state == W_RESP);
  assign axi.sram_axi_bresp   = (wr_state == W_RESP) ? wr_resp : RESP_OKAY;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_24100006_axi_sram.sv
//==============================================================================
// tb_ysyx_24100006_axi_sram : directed self-checking bench for the AXI SRAM slave
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_ysyx_24100006_axi_sram;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          MAXW = 64;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  ysyx_24100006_axi_sram_if bus ();

  ysyx_24100006_axi_sram #(
    .ADDR_BASE   (BASE),
    .DEPTH_WORDS (4096),
    .RD_LAT      (2),
    .WR_LAT      (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .axi   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ar_issue(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size);
    int n = 0;
    bus.sram_axi_arvalid = 1'b1;
    bus.sram_axi_araddr  = addr;
    bus.sram_axi_arlen   = len;
    bus.sram_axi_arsize  = size;
    while (bus.sram_axi_arready !== 1'b1 && n < MAXW) begin tick(); n++; end
    chk("ar_wait", 32'(n < MAXW), 32'd1);
    tick();
    bus.sram_axi_arvalid = 1'b0;
  endtask

  task automatic aw_issue(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size);
    int n = 0;
    bus.sram_axi_awvalid = 1'b1;
    bus.sram_axi_awaddr  = addr;
    bus.sram_axi_awlen   = len;
    bus.sram_axi_awsize  = size;
    while (bus.sram_axi_awready !== 1'b1 && n < MAXW) begin tick(); n++; end
    chk("aw_wait", 32'(n < MAXW), 32'd1);
    tick();
    bus.sram_axi_awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n = 0;
    bus.sram_axi_wvalid = 1'b1;
    bus.sram_axi_wdata  = data;
    bus.sram_axi_wstrb  = strb;
    bus.sram_axi_wlast  = last;
    while (bus.sram_axi_wready !== 1'b1 && n < MAXW) begin tick(); n++; end
    chk("w_wait", 32'(n < MAXW), 32'd1);
    tick();
    bus.sram_axi_wvalid = 1'b0;
    bus.sram_axi_wlast  = 1'b0;
  endtask

  task automatic b_check(input string tag, input logic [1:0] er);
    int n = 0;
    while (bus.sram_axi_bvalid !== 1'b1 && n < MAXW) begin tick(); n++; end
    chk({tag, "_wait"}, 32'(n < MAXW), 32'd1);
    chk({tag, "_bresp"}, 32'(bus.sram_axi_bresp), 32'(er));
    bus.sram_axi_bready = 1'b1;
    tick();
    bus.sram_axi_bready = 1'b0;
  endtask

  task automatic r_beat(input string tag, input logic [31:0] ed, input logic [1:0] er,
                        input logic el, input bit hold);
    int n = 0;
    while (bus.sram_axi_rvalid !== 1'b1 && n < MAXW) begin tick(); n++; end
    chk({tag, "_wait"}, 32'(n < MAXW), 32'd1);
    chk({tag, "_rdata"}, bus.sram_axi_rdata, ed);
    chk({tag, "_rresp"}, 32'(bus.sram_axi_rresp), 32'(er));
    chk({tag, "_rlast"}, 32'(bus.sram_axi_rlast), 32'(el));
    if (hold) begin
      tick();
      chk({tag, "_hold_rvalid"}, 32'(bus.sram_axi_rvalid), 32'd1);
      chk({tag, "_hold_rdata"}, bus.sram_axi_rdata, ed);
      chk({tag, "_hold_rlast"}, 32'(bus.sram_axi_rlast), 32'(el));
    end
    bus.sram_axi_rready = 1'b1;
    tick();
    bus.sram_axi_rready = 1'b0;
  endtask

  task automatic wr_single(input string tag, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] er);
    aw_issue(addr, 8'd0, 3'd2);
    w_beat(data, strb, 1'b1);
    b_check(tag, er);
  endtask

  task automatic rd_single(input string tag, input logic [31:0] addr, input logic [31:0] ed);
    ar_issue(addr, 8'd0, 3'd2);
    r_beat(tag, ed, 2'b00, 1'b1, 1'b0);
  endtask

  initial begin
    int n;
    int stray;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus.sram_axi_arvalid = 1'b0; bus.sram_axi_araddr = '0; bus.sram_axi_arlen = '0;
    bus.sram_axi_arsize  = '0;   bus.sram_axi_rready = 1'b0;
    bus.sram_axi_awvalid = 1'b0; bus.sram_axi_awaddr = '0; bus.sram_axi_awlen = '0;
    bus.sram_axi_awsize  = '0;   bus.sram_axi_wvalid = 1'b0; bus.sram_axi_wdata = '0;
    bus.sram_axi_wstrb   = '0;   bus.sram_axi_wlast  = 1'b0; bus.sram_axi_bready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    chk("rst_arready", 32'(bus.sram_axi_arready), 32'd1);
    chk("rst_awready", 32'(bus.sram_axi_awready), 32'd1);
    chk("rst_rvalid",  32'(bus.sram_axi_rvalid),  32'd0);
    chk("rst_bvalid",  32'(bus.sram_axi_bvalid),  32'd0);
    chk("rst_wready",  32'(bus.sram_axi_wready),  32'd0);
    chk("rst_rlast",   32'(bus.sram_axi_rlast),   32'd0);
    chk("rst_rresp",   32'(bus.sram_axi_rresp),   32'd0);
    chk("rst_bresp",   32'(bus.sram_axi_bresp),   32'd0);
    chk("rst_rdata",   bus.sram_axi_rdata,        32'd0);

    // W presented with no AW must not be accepted.
    bus.sram_axi_wvalid = 1'b1;
    tick();
    chk("w_before_aw", 32'(bus.sram_axi_wready), 32'd0);
    bus.sram_axi_wvalid = 1'b0;

    // Single write then single read with latency checks.
    aw_issue(BASE + 32'h10, 8'd0, 3'd2);
    w_beat(32'hDEADBEEF, 4'hF, 1'b1);
    chk("wr_lat_early", 32'(bus.sram_axi_bvalid), 32'd0);
    tick();
    chk("wr_lat", 32'(bus.sram_axi_bvalid), 32'd1);
    b_check("single_b", 2'b00);
    ar_issue(BASE + 32'h10, 8'd0, 3'd2);
    chk("rd_lat_early", 32'(bus.sram_axi_rvalid), 32'd0);
    tick();
    chk("rd_lat", 32'(bus.sram_axi_rvalid), 32'd1);
    r_beat("single_r", 32'hDEADBEEF, 2'b00, 1'b1, 1'b0);

    // Burst read of words 0..3 with rready held low one cycle per beat.
    aw_issue(BASE, 8'd3, 3'd2);
    for (int i = 0; i < 4; i++) w_beat(32'hC0DE_0000 + 32'(i), 4'hF, i == 3);
    b_check("pre_b", 2'b00);
    ar_issue(BASE, 8'd3, 3'd2);
    for (int i = 0; i < 4; i++) r_beat("burst", 32'hC0DE_0000 + 32'(i), 2'b00, i == 3, 1'b1);

    // Byte strobe merge.
    wr_single("strb_b0", BASE + 32'h20, 32'h11223344, 4'hF, 2'b00);
    wr_single("strb_b1", BASE + 32'h20, 32'h00AB0000, 4'b0100, 2'b00);
    rd_single("strb_r", BASE + 32'h20, 32'h11AB3344);

    // wlast ahead of awlen closes the burst.
    aw_issue(BASE + 32'h40, 8'd3, 3'd2);
    w_beat(32'h0000_0001, 4'hF, 1'b0);
    w_beat(32'h0000_0002, 4'hF, 1'b1);
    b_check("early_last_b", 2'b00);
    chk("early_last_awready", 32'(bus.sram_axi_awready), 32'd1);
    rd_single("early_last_r", BASE + 32'h44, 32'h0000_0002);

    // Out of range read and write; 0x7FFF_FFFC aliases the top word if unguarded.
    ar_issue(BASE + 32'h4000, 8'd1, 3'd2);
    r_beat("oor_r0", 32'd0, 2'b11, 1'b0, 1'b0);
    r_beat("oor_r1", 32'd0, 2'b11, 1'b1, 1'b0);
    wr_single("top_b", BASE + 32'h3FFC, 32'h0BADF00D, 4'hF, 2'b00);
    wr_single("oor_b", 32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF, 2'b11);
    rd_single("oor_top_r", BASE + 32'h3FFC, 32'h0BADF00D);

    ar_issue(BASE, 8'd0, 3'd3);
    r_beat("slverr_r", 32'd0, 2'b10, 1'b1, 1'b0);

    // Concurrent read len 3 and write len 1 on the same words.
    aw_issue(BASE + 32'h100, 8'd3, 3'd2);
    for (int i = 0; i < 4; i++) w_beat(32'hA000_0000 + 32'(i), 4'hF, i == 3);
    b_check("cc_pre_b", 2'b00);
    bus.sram_axi_arvalid = 1'b1; bus.sram_axi_araddr = BASE + 32'h100;
    bus.sram_axi_arlen   = 8'd3; bus.sram_axi_arsize = 3'd2;
    bus.sram_axi_awvalid = 1'b1; bus.sram_axi_awaddr = BASE + 32'h100;
    bus.sram_axi_awlen   = 8'd1; bus.sram_axi_awsize = 3'd2;
    chk("cc_ready", {30'd0, bus.sram_axi_arready, bus.sram_axi_awready}, 32'd3);
    tick();
    bus.sram_axi_arvalid = 1'b0;
    bus.sram_axi_awvalid = 1'b0;
    fork
      begin
        r_beat("cc_r0", 32'hA000_0000, 2'b00, 1'b0, 1'b0);
        r_beat("cc_r1", 32'h5555_0001, 2'b00, 1'b0, 1'b0);
        r_beat("cc_r2", 32'hA000_0002, 2'b00, 1'b0, 1'b0);
        r_beat("cc_r3", 32'hA000_0003, 2'b00, 1'b1, 1'b0);
      end
      begin
        w_beat(32'h5555_0000, 4'hF, 1'b0);
        w_beat(32'h5555_0001, 4'hF, 1'b1);
        b_check("cc_b", 2'b00);
      end
    join
    rd_single("cc_after_r", BASE + 32'h100, 32'h5555_0000);

    // Reset during beat 2 of a len 7 read.
    ar_issue(BASE, 8'd7, 3'd2);
    r_beat("mid_r0", 32'hC0DE_0000, 2'b00, 1'b0, 1'b0);
    r_beat("mid_r1", 32'hC0DE_0001, 2'b00, 1'b0, 1'b0);
    n = 0;
    while (bus.sram_axi_rvalid !== 1'b1 && n < MAXW) begin tick(); n++; end
    chk("mid_r2_wait", 32'(n < MAXW), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_rvalid", 32'(bus.sram_axi_rvalid), 32'd0);
    chk("mid_rst_rlast",  32'(bus.sram_axi_rlast),  32'd0);
    chk("mid_rst_rdata",  bus.sram_axi_rdata,       32'd0);
    tick();
    tick();
    reset = 1'b0;
    chk("mid_rel_arready", 32'(bus.sram_axi_arready), 32'd1);
    stray = 0;
    bus.sram_axi_rready = 1'b1;
    bus.sram_axi_bready = 1'b1;
    repeat (20) begin
      tick();
      if (bus.sram_axi_rvalid === 1'b1 || bus.sram_axi_bvalid === 1'b1) stray++;
    end
    bus.sram_axi_rready = 1'b0;
    bus.sram_axi_bready = 1'b0;
    chk("mid_stray_beats", 32'(stray), 32'd0);
    rd_single("mid_after_r", BASE, 32'hC0DE_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ysyx_24100006_axi_sram.md
YSYX_24100006_AXI_SRAM -- requirements
Module: ysyx_24100006_axi_sram

Interface
REQ-001 SHALL have parameter ADDR_BASE, 32'h8000_0000, byte address of word 0.
REQ-002 SHALL have parameter DEPTH_WORDS, 4096, number of 32-bit storage words.
REQ-003 SHALL have parameter RD_LAT, 2, cycles from AR handshake (or previous R handshake) to rvalid, legal range 1..15.
REQ-004 SHALL have parameter WR_LAT, 2, cycles from last W handshake to bvalid, legal range 1..15.
REQ-005 SHALL have one clock and asynchronous active-high reset: clk input 1 system clock; reset input 1 async active-high reset.
REQ-006 SHALL have AR ports: sram_axi_arvalid in 1; sram_axi_arready out 1; sram_axi_araddr in 32; sram_axi_arlen in 8 (beats-1); sram_axi_arsize in 3.
REQ-007 SHALL have R ports: sram_axi_rvalid out 1; sram_axi_rready in 1; sram_axi_rdata out 32; sram_axi_rresp out 2; sram_axi_rlast out 1.
REQ-008 SHALL have AW ports: sram_axi_awvalid in 1; sram_axi_awready out 1; sram_axi_awaddr in 32; sram_axi_awlen in 8; sram_axi_awsize in 3.
REQ-009 SHALL have W ports: sram_axi_wvalid in 1; sram_axi_wready out 1; sram_axi_wdata in 32 (already lane-aligned); sram_axi_wstrb in 4; sram_axi_wlast in 1.
REQ-010 SHALL have B ports: sram_axi_bvalid out 1; sram_axi_bready in 1; sram_axi_bresp out 2.

Function
REQ-011 Read FSM states SHALL be R_IDLE, R_WAIT, R_DATA; write FSM states W_IDLE, W_DATA, W_WAIT, W_RESP; the two FSMs run independently and concurrently.
REQ-012 sram_axi_arready SHALL be 1 only in R_IDLE; AR handshake latches addr, len, size, beat counter = 0, moves to R_WAIT.
REQ-013 R_WAIT SHALL count RD_LAT-1 further cycles then enter R_DATA with rvalid=1 (rvalid first high RD_LAT cycles after AR handshake).
REQ-014 In R_DATA rvalid, rdata, rresp, rlast SHALL hold stable until rready=1.
REQ-015 On R handshake with beat<len: address += 4, beat++, return to R_WAIT; with beat==len (rlast=1): return to R_IDLE.
REQ-016 rlast SHALL be 1 exactly on the beat where beat counter == latched arlen.
REQ-017 Burst type SHALL be INCR only; address increments by 4 per beat regardless of arsize; word index = (addr-ADDR_BASE)>>2, low 2 address bits ignored.
REQ-018 rresp/bresp SHALL be 2'b00 OKAY; 2'b11 DECERR when the beat address is below ADDR_BASE or index >= DEPTH_WORDS; 2'b10 SLVERR when size >2. Errored read beats return rdata=0; errored write beats leave storage unchanged.
REQ-019 sram_axi_awready SHALL be 1 only in W_IDLE; AW handshake latches addr, len, size, moves to W_DATA.
REQ-020 In W_DATA wready SHALL be 1; each W handshake writes bytes selected by wstrb to the current word, then address += 4.
REQ-021 Write burst SHALL end on the W beat with wlast=1 or on beat count == awlen, whichever first; then W_WAIT counts WR_LAT cycles, then W_RESP with bvalid=1 held until bready.
REQ-022 bresp SHALL be the worst (numerically highest) response over all beats of the burst.
REQ-023 W beats presented before AW handshake SHALL not be accepted (wready=0 outside W_DATA).
REQ-024 Same-cycle read sample and write of the same word: read SHALL return pre-write data; the write commits.
REQ-025 Burst address crossing DEPTH_WORDS SHALL not wrap; beats past the end get DECERR.

Reset
REQ-026 On reset assertion (any cycle, including mid-burst) both FSMs SHALL go immediately to IDLE; arready=1, awready=1 after release; rvalid, bvalid, wready, rlast=0; rresp, bresp=0; rdata=0.
REQ-027 Storage contents SHALL not be cleared by reset.
REQ-028 An interrupted burst SHALL produce no further R/B beats after reset release.

Structure
REQ-029 A shared package SHALL hold response codes (OKAY, SLVERR, DECERR), read/write FSM state encodings and the latency counter width.
REQ-030 One sub-module ysyx_24100006_lat_cnt (load value, start, done pulse) SHALL be instantiated twice, once per FSM.
REQ-031 Storage SHALL be a single DEPTH_WORDS x 32 array with byte-write enables.

Verification
REQ-032 Single read: AW write 32'hDEADBEEF @0x8000_0010 wstrb 4'hF, then AR 0x8000_0010 len 0 -> rvalid at AR+2 cycles, rdata DEADBEEF, rresp 00, rlast 1.
REQ-033 Burst read: AR 0x8000_0000 len 3, rready toggled 1/0 -> 4 beats from words 0..3 in order, rlast only on 4th, data stable while rready=0.
REQ-034 Byte strobe: word = 32'h11223344, write wdata 32'h00AB0000 wstrb 4'b0100 -> readback 32'h11AB3344, bresp 00.
REQ-035 Out of range: AR 0x8000_4000 (DEPTH 4096) len 1 -> both beats rresp 11, rdata 0; AW 0x7FFF_FFFC -> bresp 11, no storage change.
REQ-036 Concurrency: read burst len 3 and write burst len 1 issued same cycle -> both complete, bresp 00, rdata per REQ-024.
REQ-037 Reset mid-burst: assert reset during beat 2 of a len 7 read -> rvalid 0 same cycle, arready 1 after release, no stray beats; subsequent single read correct.
